mux8_rr_scheduler: RTL and testbench
====================================

Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux among 8 requesters.
- Requester k owns data input I[k] and raises req[k] to get the mux.
- The block picks a winner, drives the mux select lines S2,S1,S0 and a one-hot grant, holds the grant for up to MAX_HOLD cycles, and presents the selected bit on a registered output Y with a valid strobe.
- Sits between the requester fabric and downstream single-bit consumers; contains the 8:1 selection internally.

Parameters:
- MAX_HOLD, 4, max consecutive cycles one requester keeps the grant per tenure; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  8  request vector; req[k]=1 means requester k wants the mux.
- I  input  8  data inputs; I[k] belongs to requester k.
- S2  output  1  select MSB (registered).
- S1  output  1  select mid bit (registered).
- S0  output  1  select LSB (registered).
- gnt  output  8  one-hot grant, consistent with {S2,S1,S0} while busy (registered).
- busy  output  1  1 while in GRANT state.
- Y  output  1  registered I[{S2,S1,S0}], sampled during the previous GRANT cycle.
- valid  output  1  Y carries granted data.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n is sampled only on the clk rising edge; rst_n=0 at an edge forces reset regardless of req.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, {S2,S1,S0}=000, gnt=0, busy=0, Y=0, valid=0.
- Internal state:
  - ptr: 3-bit round-robin start index.
  - hold_cnt: 8-bit tenure counter.
  - sel: {S2,S1,S0}.
- Arbitration function win(req, ptr): first k scanning ptr, ptr+1, ..., ptr+7 (mod 8) with req[k]=1. "None" if req=0.
- IDLE:
  - req=0: stay IDLE.
  - Otherwise, next edge: state=GRANT, sel=win, gnt=1<<win, hold_cnt=0, ptr=win+1 (mod 8, 7 wraps to 0).
  - Latency req->gnt is 1 cycle.
- GRANT, hold condition: if req[sel]=1 and hold_cnt < MAX_HOLD-1, then hold_cnt++ and sel/gnt are unchanged.
- GRANT, release condition: req[sel]=0 or hold_cnt == MAX_HOLD-1. Re-arbitrate with win(req, ptr) in the same cycle:
  - Winner exists: next edge loads the new sel/gnt, hold_cnt=0, ptr=win+1. There is no idle gap between tenures.
  - No winner: next edge state=IDLE, gnt=0, busy=0. sel keeps its last value.
- Self re-grant: if the released requester is the only one still requesting, it wins again (it is scanned last) and gets a fresh tenure with hold_cnt=0.
- Data path: every edge, Y <= I[sel] and valid <= 1 if state was GRANT; otherwise Y <= 0 and valid <= 0. Y/valid therefore lag gnt by exactly 1 cycle.
- Deassertion: dropping req[k] mid-tenure ends the grant at the next edge. That cycle's I[sel] is still delivered on Y at the next edge.
- MAX_HOLD=1: every GRANT cycle is a release; grants rotate every cycle.
- Simultaneous requests are resolved only by ptr; there is no fixed priority beyond the reset value ptr=0.
- Reset mid-tenure: the next edge gives reset values. The first post-reset grant uses ptr=0.
- Invariant: gnt is zero or one-hot, and gnt[k]=1 implies sel=k and busy=1.

Test Plan:
- Reset with activity: rst_n=0 with req=FF, I=FF for 3 cycles -> gnt=00, S=000, busy=0, Y=0, valid=0 throughout. Release rst_n -> gnt=01 one cycle later.
- Single requester, MAX_HOLD=4: req=08 held 12 cycles, I[3] toggling -> gnt=08 continuously, hold_cnt cycles 0..3 with self re-grant, valid=1 from the 2nd GRANT cycle, Y equals I[3] delayed 1 cycle.
- Two requesters: req=81 constant from reset, MAX_HOLD=4 -> gnt sequence 01×4, 80×4, 01×4, with no busy gap.
- All request, MAX_HOLD=1: req=FF -> S steps 0,1,2,...,7,0 one per cycle; gnt rotates 01,02,...,80,01.
- Early release: grant on 2 (req=24), drop req[2] after 2 GRANT cycles -> next edge gnt=20 (S=101), hold_cnt=0, busy stays 1. Then drop req[5] -> IDLE, gnt=00, valid falls 1 cycle later.
- Mid-tenure reset: req=FF with gnt=10 (ptr=5), pulse rst_n=0 for 1 cycle -> all outputs at reset values. The next grant is index 0, not 5.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// Each grant tenure lasts up to MAX_HOLD cycles. The selected bit is registered onto Y together with a valid strobe.
module mux8_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] I,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       Y,
    output logic       valid
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] sel, sel_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [7:0] gnt_r, gnt_nxt;
    logic       y_r, valid_r;
    logic       win_found;
    logic [2:0] win_idx;
    logic       release_now;

    // The scan starts at ptr, so the last winner is always checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int i = 0; i < 8; i++) begin
            if (!win_found && req[ptr + 3'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 3'(i);
            end
        end
    end

    assign release_now = !req[sel] || (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            sel      <= 3'd0;
            hold_cnt <= 8'd0;
            gnt_r    <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            hold_cnt <= hold_nxt;
            gnt_r    <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt_r;
        if (state == GRANT && !release_now) begin
            hold_nxt = hold_cnt + 8'd1;
        end else if (win_found) begin
            state_nxt = GRANT;
            sel_nxt   = win_idx;
            gnt_nxt   = 8'd1 << win_idx;
            hold_nxt  = 8'd0;
            ptr_nxt   = win_idx + 3'd1;
        end else begin
            // With no winner, the FSM drops to IDLE and sel keeps its last value.
            state_nxt = IDLE;
            gnt_nxt   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r     <= 1'b0;
            valid_r <= 1'b0;
        end else if (state == GRANT) begin
            y_r     <= I[sel];
            valid_r <= 1'b1;
        end else begin
            y_r     <= 1'b0;
            valid_r <= 1'b0;
        end
    end

    always_comb begin
        busy         = (state == GRANT);
        {S2, S1, S0} = sel;
        gnt          = gnt_r;
        Y            = y_r;
        valid        = valid_r;
    end
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler. Instance 0 uses MAX_HOLD=4 and instance 1 uses MAX_HOLD=1.
// Both instances are checked every cycle against a spec-level model, plus directed tables and sequences.
module tb_mux8_rr_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] data = 8'd0;

    logic [7:0] gnt0, gnt1;
    logic [2:0] sel0, sel1;
    logic       busy0, busy1, y0, y1, v0, v1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux8_rr_scheduler #(.MAX_HOLD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .I(data),
        .S2(sel0[2]), .S1(sel0[1]), .S0(sel0[0]),
        .gnt(gnt0), .busy(busy0), .Y(y0), .valid(v0)
    );

    mux8_rr_scheduler #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .I(data),
        .S2(sel1[2]), .S1(sel1[1]), .S0(sel1[0]),
        .gnt(gnt1), .busy(busy1), .Y(y1), .valid(v1)
    );

    // Reference model: plain integers per instance
    int m_hold_max[2] = '{4, 1};
    int m_busy[2], m_sel[2], m_ptr[2], m_hold[2], m_y[2], m_v[2];

    function automatic int win(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    task automatic model_edge();
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_busy[j] = 0; m_sel[j] = 0; m_ptr[j] = 0;
                m_hold[j] = 0; m_y[j] = 0; m_v[j] = 0;
            end else begin
                int w;
                m_y[j] = m_busy[j] ? int'(data[m_sel[j]]) : 0;
                m_v[j] = m_busy[j];
                if (m_busy[j] && req[m_sel[j]] && m_hold[j] < m_hold_max[j] - 1) begin
                    m_hold[j]++;
                end else begin
                    w = win(req, m_ptr[j]);
                    if (w >= 0) begin
                        m_busy[j] = 1; m_sel[j] = w; m_hold[j] = 0; m_ptr[j] = (w + 1) % 8;
                    end else begin
                        m_busy[j] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] eg0, eg1;
        eg0 = m_busy[0] ? (8'd1 << m_sel[0]) : 8'd0;
        eg1 = m_busy[1] ? (8'd1 << m_sel[1]) : 8'd0;
        check("m0_gnt", 32'(gnt0), 32'(eg0));
        check("m0_sel", 32'(sel0), 32'(m_sel[0]));
        check("m0_busy", 32'(busy0), 32'(m_busy[0]));
        check("m0_y", 32'(y0), 32'(m_y[0]));
        check("m0_valid", 32'(v0), 32'(m_v[0]));
        check("m1_gnt", 32'(gnt1), 32'(eg1));
        check("m1_sel", 32'(sel1), 32'(m_sel[1]));
        check("m1_busy", 32'(busy1), 32'(m_busy[1]));
        check("m1_y", 32'(y1), 32'(m_y[1]));
        check("m1_valid", 32'(v1), 32'(m_v[1]));
    endtask

    // Apply the current inputs across one edge, then sample the outputs and check them against the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] d);
        rst_n = r; req = rq; data = d;
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] data;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
        logic       valid;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Reset under activity, then two requesters on instance 0 (MAX_HOLD=4)
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 4; i < 7; i++) vecs[i] = '{1'b1, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 8'h81, 8'h01, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        for (int i = 8; i < 11; i++) vecs[i] = '{1'b1, 8'h81, 8'h01, 8'h80, 3'd7, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        for (int i = 12; i < 15; i++) vecs[i] = '{1'b1, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].data);
            step();
            check($sformatf("tbl%0d_gnt", i), 32'(gnt0), 32'(vecs[i].gnt));
            check($sformatf("tbl%0d_sel", i), 32'(sel0), 32'(vecs[i].sel));
            check($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
            check($sformatf("tbl%0d_y", i), 32'(y0), 32'(vecs[i].y));
            check($sformatf("tbl%0d_valid", i), 32'(v0), 32'(vecs[i].valid));
        end

        // All requesting on instance 1 (MAX_HOLD=1): the select rotates every cycle
        drive(1'b0, 8'hFF, 8'h00); step();
        drive(1'b1, 8'hFF, 8'h00);
        for (int i = 0; i < 9; i++) begin
            step();
            check("rot_sel", 32'(sel1), 32'(i % 8));
            check("rot_gnt", 32'(gnt1), 32'(8'd1 << (i % 8)));
        end

        // Early release, then drop to IDLE (instance 0)
        drive(1'b0, 8'h00, 8'h00); step();
        drive(1'b1, 8'h24, 8'h04); step();
        check("er_gnt2", 32'(gnt0), 32'h04);
        step();
        drive(1'b1, 8'h20, 8'h04); step();
        check("er_gnt5", 32'(gnt0), 32'h20);
        check("er_sel5", 32'(sel0), 32'd5);
        check("er_busy", 32'(busy0), 32'd1);
        drive(1'b1, 8'h00, 8'h00); step();
        check("er_idle_gnt", 32'(gnt0), 32'h00);
        check("er_idle_busy", 32'(busy0), 32'd0);
        check("er_valid_lag", 32'(v0), 32'd1);
        step();
        check("er_valid_low", 32'(v0), 32'd0);

        // Mid-tenure reset: run until gnt=10 (ptr=5), then pulse reset
        drive(1'b0, 8'hFF, 8'hFF); step();
        drive(1'b1, 8'hFF, 8'hFF);
        begin
            int guard = 0;
            do begin
                step();
                guard++;
            end while (gnt0 !== 8'h10 && guard < 40);
            check("mr_reach_gnt10", 32'(gnt0), 32'h10);
        end
        drive(1'b0, 8'hFF, 8'hFF); step();
        check("mr_gnt", 32'(gnt0), 32'h00);
        check("mr_sel", 32'(sel0), 32'd0);
        check("mr_busy", 32'(busy0), 32'd0);
        check("mr_y", 32'(y0), 32'd0);
        check("mr_valid", 32'(v0), 32'd0);
        drive(1'b1, 8'hFF, 8'hFF); step();
        check("mr_first_gnt", 32'(gnt0), 32'h01);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            drive(($urandom_range(0, 99) != 0), r, 8'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
